// File: rtl/stream_sched_pkg.sv
// rtl/stream_sched_pkg.sv - shared types and defaults for the frame scheduler
package stream_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 24;
  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_V_ACTIVE = 1080;

endpackage

// File: rtl/stream_frame_counter.sv
// rtl/stream_frame_counter.sv - column/row position counter with end-of-line/frame flags
module stream_frame_counter #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int COL_W    = 11,
  parameter int ROW_W    = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             beat,
  input  logic             clr,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             eol,
  output logic             eof
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    eol   = (col_q == COL_W'(H_ACTIVE - 1));
    eof   = eol && (row_q == ROW_W'(V_ACTIVE - 1));
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (beat) begin
      col_d = eol ? '0 : col_q + 1'b1;
      if (eol) begin
        row_d = eof ? '0 : row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/stream_frame_sched.sv
// rtl/stream_frame_sched.sv - frame-granular round-robin sharing of one video stream output
module stream_frame_sched
  import stream_sched_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic                aclk,
  input  logic                areset_n,
  input  logic [1:0]          src_en,
  input  logic [DATA_W-1:0]   s0_axis_tdata,
  input  logic                s0_axis_tvalid,
  input  logic                s0_axis_tuser,
  input  logic                s0_axis_tlast,
  output logic                s0_axis_tready,
  input  logic [DATA_W-1:0]   s1_axis_tdata,
  input  logic                s1_axis_tvalid,
  input  logic                s1_axis_tuser,
  input  logic                s1_axis_tlast,
  output logic                s1_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  input  logic                m_axis_tready,
  output logic                grant,
  output logic                busy,
  output logic                err_sof,
  output logic                err_eol,
  output logic [15:0]         frame_cnt0,
  output logic [15:0]         frame_cnt1
);

  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;
  logic [1:0]  en_q, en_d;
  logic [15:0] fc0_q, fc0_d, fc1_q, fc1_d;

  logic [1:0]  s_tvalid, s_tuser, s_tlast, s_tready;
  logic [1:0]  en_eff, req, drain_rdy;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic        eol, eof, beat, clr, sof_pos, sof_bad;

  assign s_tvalid = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_tuser  = {s1_axis_tuser,  s0_axis_tuser};
  assign s_tlast  = {s1_axis_tlast,  s0_axis_tlast};

  stream_frame_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_counter (
    .clk    (aclk),
    .resetn (areset_n),
    .beat   (beat),
    .clr    (clr),
    .col    (col),
    .row    (row),
    .eol    (eol),
    .eof    (eof)
  );

  // Enables are frozen for the duration of a frame; the live value applies only in IDLE.
  always_comb begin
    en_eff = (state_q == ST_IDLE) ? src_en : en_q;
    for (int i = 0; i < 2; i++) begin
      req[i]       = en_eff[i] & s_tvalid[i] & s_tuser[i];
      drain_rdy[i] = ~en_eff[i] | (s_tvalid[i] & ~s_tuser[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    en_d          = en_eff;
    fc0_d         = fc0_q;
    fc1_d         = fc1_q;
    s_tready      = drain_rdy;
    m_axis_tdata  = grant_q ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    err_sof       = 1'b0;
    err_eol       = 1'b0;
    busy          = 1'b0;
    beat          = 1'b0;
    clr           = 1'b1;
    sof_pos       = (col == '0) && (row == '0);
    sof_bad       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_PASS;
          grant_d = (&req) ? rr_q : req[1];
        end
      end
      ST_PASS: begin
        busy    = 1'b1;
        clr     = 1'b0;
        // A start-of-frame mid-frame is refused so it can open the next frame.
        sof_bad = s_tvalid[grant_q] & s_tuser[grant_q] & ~sof_pos;
        m_axis_tvalid     = s_tvalid[grant_q] & ~sof_bad;
        m_axis_tuser      = sof_pos;
        m_axis_tlast      = eol;
        s_tready[grant_q] = m_axis_tready & ~sof_bad;
        beat    = m_axis_tvalid & m_axis_tready;
        err_eol = beat & (s_tlast[grant_q] != eol);
        err_sof = sof_bad;
        if (sof_bad) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else if (beat && eof) begin
          state_d = ST_IDLE;
          rr_d    = ~grant_q;
          if (grant_q) fc1_d = fc1_q + 16'd1;
          else         fc0_d = fc0_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!areset_n) s_tready = 2'b00;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      en_q    <= 2'b00;
      fc0_q   <= 16'd0;
      fc1_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      fc0_q   <= fc0_d;
      fc1_q   <= fc1_d;
    end
  end

  assign s0_axis_tready = s_tready[0];
  assign s1_axis_tready = s_tready[1];
  assign m_axis_tkeep   = '1;
  assign grant          = grant_q;
  assign frame_cnt0     = fc0_q;
  assign frame_cnt1     = fc1_q;

endmodule

// File: tb/tb_stream_frame_sched.sv
// tb/tb_stream_frame_sched.sv - randomized self-checking bench for stream_frame_sched
module tb_stream_frame_sched;

  localparam int DW = 24;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FB = H * V;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  logic          aclk, areset_n;
  logic [1:0]    src_en;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tuser, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tuser, s1_tlast, s1_tready;
  logic          m_tvalid, m_tuser, m_tlast, m_tready;
  logic [DW/8-1:0] m_tkeep;
  logic          grant, busy, err_sof, err_eol;
  logic [15:0]   frame_cnt0, frame_cnt1;

  stream_frame_sched #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .aclk           (aclk),
    .areset_n       (areset_n),
    .src_en         (src_en),
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tuser  (s0_tuser),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tuser  (s1_tuser),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tready  (m_tready),
    .grant          (grant),
    .busy           (busy),
    .err_sof        (err_sof),
    .err_eol        (err_eol),
    .frame_cnt0     (frame_cnt0),
    .frame_cnt1     (frame_cnt1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  beat_t q0[$], q1[$];
  beat_t out_q[$], exp_q[$], frm[$];
  logic  out_g[$];
  int    out_cyc[$];
  logic  busy_hist[$], rdy0_hist[$], rdy1_hist[$];
  int    cyc, hs1_cnt, sof_cnt, sof_cyc, eol_cnt, eol_idx, stall_viol;
  bit    mready_rand, stall_prev;
  logic [DW-1:0] stall_data;

  task automatic gen_frame();
    frm = {};
    for (int k = 0; k < FB; k++)
      frm.push_back('{d: DW'($urandom), u: (k == 0), l: ((k % H) == H - 1)});
  endtask

  // Reference: the output is the source pixel sequence with framing regenerated from position.
  task automatic add_exp(input beat_t src[$]);
    for (int k = 0; k < src.size(); k++)
      exp_q.push_back('{d: src[k].d, u: (k == 0), l: ((k % H) == H - 1)});
  endtask

  task automatic cycle();
    m_tready = mready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    s0_tvalid = q0.size() > 0;
    s0_tdata  = s0_tvalid ? q0[0].d : '0;
    s0_tuser  = s0_tvalid ? q0[0].u : 1'b0;
    s0_tlast  = s0_tvalid ? q0[0].l : 1'b0;
    s1_tvalid = q1.size() > 0;
    s1_tdata  = s1_tvalid ? q1[0].d : '0;
    s1_tuser  = s1_tvalid ? q1[0].u : 1'b0;
    s1_tlast  = s1_tvalid ? q1[0].l : 1'b0;
    @(negedge aclk);
    busy_hist.push_back(busy);
    rdy0_hist.push_back(s0_tready);
    rdy1_hist.push_back(s1_tready);
    if (stall_prev && !(m_tvalid === 1'b1 && m_tdata === stall_data)) stall_viol++;
    stall_prev = m_tvalid && !m_tready;
    stall_data = m_tdata;
    if (m_tvalid && m_tready) begin
      out_q.push_back('{d: m_tdata, u: m_tuser, l: m_tlast});
      out_g.push_back(grant);
      out_cyc.push_back(cyc);
    end
    if (err_sof) begin sof_cnt++; sof_cyc = cyc; end
    if (err_eol) begin eol_cnt++; eol_idx = out_q.size() - 1; end
    begin
      bit p0, p1;
      p0 = s0_tvalid && s0_tready;
      p1 = s1_tvalid && s1_tready;
      if (p1) hs1_cnt++;
      cyc++;
      @(posedge aclk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
    end
    #1;
  endtask

  task automatic clear_logs();
    out_q = {}; exp_q = {}; out_g = {}; out_cyc = {};
    busy_hist = {}; rdy0_hist = {}; rdy1_hist = {};
    cyc = 0; hs1_cnt = 0; sof_cnt = 0; sof_cyc = -1; eol_cnt = 0; eol_idx = -1;
    stall_viol = 0; stall_prev = 0; stall_data = '0;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    q0 = {}; q1 = {};
    mready_rand = 0;
    src_en = 2'b00;
    repeat (2) cycle();
    areset_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && out_q.size() < n; i++) cycle();
    ok = out_q.size() >= n;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    src_en = 2'b11;
    clear_logs();
    gen_frame(); q0 = frm;
    gen_frame(); q1 = frm;
    repeat (3) cycle();
    checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin failures++;
      $display("FAIL reset_tready got=%b%b want=00", s1_tready, s0_tready); end
    checks++; if ({m_tvalid, m_tuser, m_tlast, busy, grant} !== 5'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {m_tvalid, m_tuser, m_tlast, busy, grant}); end
    checks++; if (frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0 || err_sof !== 1'b0 || err_eol !== 1'b0) begin failures++;
      $display("FAIL reset_counts got=%0d/%0d err=%b%b want=0/0 00", frame_cnt0, frame_cnt1, err_sof, err_eol); end
    checks++; if (m_tkeep !== 3'b111) begin failures++;
      $display("FAIL tkeep got=%b want=111", m_tkeep); end
  endtask

  task automatic test_single_frame();
    bit ok;
    do_reset();
    src_en = 2'b01;
    gen_frame(); q0 = frm; add_exp(frm);
    run_until(FB, 50, ok);
    cycle();
    checks++; if (!ok) begin failures++;
      $display("FAIL single_timeout got=%0d beats want=%0d", out_q.size(), FB); end
    for (int k = 0; k < exp_q.size(); k++) begin
      beat_t g;
      g = (k < out_q.size()) ? out_q[k] : '0;
      checks++; if (g !== exp_q[k]) begin failures++;
        $display("FAIL single_beat%0d got=%h want=%h", k, g, exp_q[k]); end
    end
    checks++; if (frame_cnt0 !== 16'd1 || frame_cnt1 !== 16'd0) begin failures++;
      $display("FAIL single_fcnt got=%0d/%0d want=1/0", frame_cnt0, frame_cnt1); end
    if (ok) begin
      checks++; if (busy_hist[out_cyc[FB-1] + 1] !== 1'b0) begin failures++;
        $display("FAIL single_busy_after got=%b want=0", busy_hist[out_cyc[FB-1] + 1]); end
      checks++; if (busy_hist[out_cyc[FB-1]] !== 1'b1) begin failures++;
        $display("FAIL single_busy_last got=%b want=1", busy_hist[out_cyc[FB-1]]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic want_g [3];
    do_reset();
    src_en = 2'b11;
    want_g[0] = 1'b0; want_g[1] = 1'b1; want_g[2] = 1'b0;
    gen_frame(); q0 = frm; add_exp(frm);
    gen_frame(); q1 = frm; add_exp(frm);
    gen_frame(); foreach (frm[i]) q0.push_back(frm[i]); add_exp(frm);
    run_until(3 * FB, 200, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL rr_timeout got=%0d beats want=%0d", out_q.size(), 3 * FB); end
    checks++; if (rdy1_hist[0] !== 1'b0 || rdy1_hist[1] !== 1'b0) begin failures++;
      $display("FAIL rr_s1_held got=%b%b want=00", rdy1_hist[0], rdy1_hist[1]); end
    if (ok) begin
      for (int f = 0; f < 3; f++) begin
        checks++; if (out_g[f * FB] !== want_g[f]) begin failures++;
          $display("FAIL rr_grant%0d got=%b want=%b", f, out_g[f * FB], want_g[f]); end
      end
      checks++; if (out_cyc[FB] - out_cyc[FB-1] != 2) begin failures++;
        $display("FAIL rr_bubble got=%0d want=2", out_cyc[FB] - out_cyc[FB-1]); end
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      beat_t g;
      g = (k < out_q.size()) ? out_q[k] : '0;
      checks++; if (g !== exp_q[k]) begin failures++;
        $display("FAIL rr_beat%0d got=%h want=%h", k, g, exp_q[k]); end
    end
    checks++; if (frame_cnt0 !== 16'd2 || frame_cnt1 !== 16'd1) begin failures++;
      $display("FAIL rr_fcnt got=%0d/%0d want=2/1", frame_cnt0, frame_cnt1); end
  endtask

  task automatic test_resync();
    bit ok;
    do_reset();
    src_en = 2'b10;
    for (int j = 0; j < 3; j++) q1.push_back('{d: DW'($urandom), u: 1'b0, l: 1'b0});
    gen_frame(); foreach (frm[i]) q1.push_back(frm[i]); add_exp(frm);
    run_until(FB, 60, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL resync_timeout got=%0d beats want=%0d", out_q.size(), FB); end
    checks++; if (hs1_cnt != FB + 3) begin failures++;
      $display("FAIL resync_accepted got=%0d want=%0d", hs1_cnt, FB + 3); end
    for (int k = 0; k < exp_q.size(); k++) begin
      beat_t g;
      g = (k < out_q.size()) ? out_q[k] : '0;
      checks++; if (g !== exp_q[k]) begin failures++;
        $display("FAIL resync_beat%0d got=%h want=%h", k, g, exp_q[k]); end
    end
    checks++; if (out_q.size() > 0 && out_g[0] !== 1'b1) begin failures++;
      $display("FAIL resync_grant got=%b want=1", out_g[0]); end
  endtask

  task automatic test_sof_error();
    bit ok;
    beat_t part[$];
    do_reset();
    src_en = 2'b01;
    gen_frame(); part = frm[0:5]; q0 = part; add_exp(part);
    gen_frame(); foreach (frm[i]) q0.push_back(frm[i]); add_exp(frm);
    run_until(6 + FB, 80, ok);
    cycle();
    checks++; if (!ok) begin failures++;
      $display("FAIL sof_timeout got=%0d beats want=%0d", out_q.size(), 6 + FB); end
    checks++; if (sof_cnt != 1) begin failures++;
      $display("FAIL sof_pulses got=%0d want=1", sof_cnt); end
    if (sof_cyc >= 0) begin
      checks++; if (busy_hist[sof_cyc + 1] !== 1'b0) begin failures++;
        $display("FAIL sof_idle_after got=%b want=0", busy_hist[sof_cyc + 1]); end
      checks++; if (rdy0_hist[sof_cyc] !== 1'b0) begin failures++;
        $display("FAIL sof_not_taken got=%b want=0", rdy0_hist[sof_cyc]); end
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      beat_t g;
      g = (k < out_q.size()) ? out_q[k] : '0;
      checks++; if (g !== exp_q[k]) begin failures++;
        $display("FAIL sof_beat%0d got=%h want=%h", k, g, exp_q[k]); end
    end
    checks++; if (frame_cnt0 !== 16'd1) begin failures++;
      $display("FAIL sof_fcnt got=%0d want=1", frame_cnt0); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    src_en = 2'b01;
    mready_rand = 1;
    gen_frame(); q0 = frm; add_exp(frm);
    gen_frame(); foreach (frm[i]) q0.push_back(frm[i]); add_exp(frm);
    run_until(2 * FB, 400, ok);
    mready_rand = 0;
    checks++; if (!ok) begin failures++;
      $display("FAIL bp_timeout got=%0d beats want=%0d", out_q.size(), 2 * FB); end
    checks++; if (out_q.size() != exp_q.size()) begin failures++;
      $display("FAIL bp_count got=%0d want=%0d", out_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      beat_t g;
      g = (k < out_q.size()) ? out_q[k] : '0;
      checks++; if (g !== exp_q[k]) begin failures++;
        $display("FAIL bp_beat%0d got=%h want=%h", k, g, exp_q[k]); end
    end
    checks++; if (stall_viol != 0) begin failures++;
      $display("FAIL bp_stable got=%0d unstable stalls want=0", stall_viol); end
    checks++; if (frame_cnt0 !== 16'd2) begin failures++;
      $display("FAIL bp_fcnt got=%0d want=2", frame_cnt0); end
  endtask

  task automatic test_eol_error();
    bit ok;
    do_reset();
    src_en = 2'b01;
    gen_frame(); frm[1].l = 1'b1; q0 = frm; add_exp(frm);
    run_until(FB, 50, ok);
    cycle();
    checks++; if (!ok) begin failures++;
      $display("FAIL eol_timeout got=%0d beats want=%0d", out_q.size(), FB); end
    checks++; if (eol_cnt != 1 || eol_idx != 1) begin failures++;
      $display("FAIL eol_pulse got=%0d@%0d want=1@1", eol_cnt, eol_idx); end
    for (int k = 0; k < exp_q.size(); k++) begin
      beat_t g;
      g = (k < out_q.size()) ? out_q[k] : '0;
      checks++; if (g !== exp_q[k]) begin failures++;
        $display("FAIL eol_beat%0d got=%h want=%h", k, g, exp_q[k]); end
    end
    checks++; if (frame_cnt0 !== 16'd1) begin failures++;
      $display("FAIL eol_fcnt got=%0d want=1", frame_cnt0); end
  endtask

  initial begin
    areset_n = 1'b0; src_en = 2'b00; m_tready = 1'b1;
    s0_tdata = '0; s0_tvalid = 0; s0_tuser = 0; s0_tlast = 0;
    s1_tdata = '0; s1_tvalid = 0; s1_tuser = 0; s1_tlast = 0;
    mready_rand = 0;
    @(posedge aclk); #1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_resync();
    test_sof_error();
    test_backpressure();
    test_eol_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
